// File: rtl/serial_link_pkg.sv
// Shared definitions for the two-lane bit-serial link (transmitter and receiver).
package serial_link_pkg;

  localparam int unsigned SER_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    HOLD
  } collector_state_t;

endpackage

// File: rtl/serial_lane_capture.sv
// One lane of the collector: bit-indexed assembly register plus the presented output word.
module serial_lane_capture
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] idx,
  input  logic             wr_en,
  input  logic             copy_en,
  output logic [WIDTH-1:0] word
);

  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] asm_next_c;

  // The copy takes the updated value so the final sampled bit lands in the word.
  always_comb begin
    asm_next_c = asm_q;
    if (wr_en) asm_next_c[idx] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= '0;
      word  <= '0;
    end else begin
      asm_q <= asm_next_c;
      if (copy_en) word <= asm_next_c;
    end
  end

endmodule

// File: rtl/dual_serial_collector.sv
// Receive side of the two-lane serial link: reassembles LSB-first frames into word pairs
// and presents them under a valid/ready handshake.
module dual_serial_collector
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_1,
  input  logic             in_2,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  collector_state_t state_q;
  logic [CNT_W-1:0] cnt_q;

  logic             wr_en_c;
  logic             copy_en_c;
  logic [CNT_W-1:0] idx_c;
  logic             last_c;

  assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

  // Lane write/copy strobes; a start always writes bit 0, otherwise RECV writes bit cnt.
  always_comb begin
    wr_en_c   = 1'b0;
    copy_en_c = 1'b0;
    idx_c     = '0;
    case (state_q)
      IDLE: wr_en_c = start;
      RECV: begin
        wr_en_c = 1'b1;
        if (!start) begin
          idx_c     = cnt_q;
          copy_en_c = last_c;
        end
      end
      HOLD: wr_en_c = out_ready & start;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= CNT_W'(1);
            busy    <= 1'b1;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (start) begin
            cnt_q <= CNT_W'(1);
          end else if (last_c) begin
            cnt_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              cnt_q   <= CNT_W'(1);
              busy    <= 1'b1;
              state_q <= RECV;
            end else begin
              state_q <= IDLE;
            end
          end else if (start) begin
            overrun <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  serial_lane_capture #(.WIDTH(WIDTH)) u_lane_1 (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (in_1),
    .idx     (idx_c),
    .wr_en   (wr_en_c),
    .copy_en (copy_en_c),
    .word    (out_1)
  );

  serial_lane_capture #(.WIDTH(WIDTH)) u_lane_2 (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (in_2),
    .idx     (idx_c),
    .wr_en   (wr_en_c),
    .copy_en (copy_en_c),
    .word    (out_2)
  );

endmodule

// File: tb/tb_dual_serial_collector.sv
// Scoreboard bench for dual_serial_collector: directed scenarios then random traffic
// against a bit-list reference model.
module tb_dual_serial_collector;
  import serial_link_pkg::*;

  localparam int unsigned W = SER_WIDTH;

  typedef struct {
    logic [W-1:0] w1;
    logic [W-1:0] w2;
  } pair_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         in_1;
  logic         in_2;
  logic [W-1:0] out_1;
  logic [W-1:0] out_2;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 0;

  dual_serial_collector dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_1      (in_1),
    .in_2      (in_2),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is the list of samples since the last accepted start.
  logic  m_bits1[$];
  logic  m_bits2[$];
  bit    m_collect = 0;
  bit    m_hold = 0;
  bit    m_ovr = 0;
  logic [W-1:0] m_out1 = '0;
  logic [W-1:0] m_out2 = '0;
  pair_t exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_bits1.delete();
      m_bits2.delete();
      m_collect = 0;
      m_hold    = 0;
      m_ovr     = 0;
      m_out1    = '0;
      m_out2    = '0;
      exp_q.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        if (start) begin
          m_bits1 = {in_1};
          m_bits2 = {in_2};
          m_collect = 1;
        end
      end else if (start) begin
        m_ovr = 1;
      end
    end else if (start) begin
      m_bits1 = {in_1};
      m_bits2 = {in_2};
      m_collect = 1;
    end else if (m_collect) begin
      m_bits1.push_back(in_1);
      m_bits2.push_back(in_2);
      if (m_bits1.size() == W) begin
        pair_t p;
        for (int k = 0; k < W; k++) begin
          p.w1[k] = m_bits1[k];
          p.w2[k] = m_bits2[k];
        end
        m_out1 = p.w1;
        m_out2 = p.w2;
        exp_q.push_back(p);
        m_hold = 1;
        m_collect = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Monitor: per-cycle status against the model, word pairs popped on each handshake.
  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", W'(out_valid), W'(m_hold));
      chk("busy", W'(busy), W'(m_collect));
      chk("overrun", W'(overrun), W'(m_ovr));
      chk("out_1", out_1, m_out1);
      chk("out_2", out_2, m_out2);
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_frame", W'(1), W'(0));
        end else begin
          pair_t e;
          e = exp_q.pop_front();
          chk("sb_word_1", out_1, e.w1);
          chk("sb_word_2", out_2, e.w2);
        end
      end
    end
  end

  task automatic drive(input logic s, input logic b1, input logic b2);
    start = s;
    in_1  = b1;
    in_2  = b2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_bits(input logic [W-1:0] w1, input logic [W-1:0] w2, input int n);
    for (int k = 0; k < n; k++) drive(k == 0, w1[k], w2[k]);
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] lane1;
    logic [W-1:0] a;
    rst = 1'b1;
    start = 1'b0;
    in_1 = 1'b0;
    in_2 = 1'b0;
    out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'($urandom);
      drive(1'($urandom), 1'($urandom), 1'($urandom));
      checking = 1;
    end
    rst = 1'b0;
    out_ready = 1'b0;
    idle(2);

    // Known pattern with immediate acceptance
    lane1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    out_ready = 1'b1;
    send_bits(lane1, ~lane1, W);
    idle(5);

    // Consumer stalls for 20 cycles
    out_ready = 1'b0;
    send_bits(rand_word(), rand_word(), W);
    idle(20);
    out_ready = 1'b1;
    idle(3);

    // Back-to-back frames, second start on the handshake cycle
    send_bits(rand_word(), rand_word(), W);
    send_bits(128'h1, rand_word(), W);
    idle(3);

    // Dropped frame sets overrun; then a restart at bit 60
    out_ready = 1'b0;
    send_bits(rand_word(), rand_word(), W);
    idle(3);
    drive(1'b1, 1'($urandom), 1'($urandom));
    idle(3);
    out_ready = 1'b1;
    idle(2);
    send_bits(rand_word(), rand_word(), 60);
    send_bits(rand_word(), rand_word(), W);
    idle(3);

    // Reset in the middle of a frame, then a clean frame
    a = rand_word();
    send_bits(a, ~a, 64);
    rst = 1'b1;
    drive(1'b0, 1'($urandom), 1'($urandom));
    rst = 1'b0;
    send_bits(rand_word(), rand_word(), W);
    idle(3);

    // Random traffic: sparse starts, random ready, rare resets
    for (int i = 0; i < 3000; i++) begin
      out_ready = 1'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      drive($urandom_range(0, 149) == 0, 1'($urandom), 1'($urandom));
    end
    rst = 1'b0;
    out_ready = 1'b1;
    idle(W + 10);
    chk("sb_drain", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
